// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU-sharing arbiter:
//   - controller state encoding (IDLE / EXEC / RESP)
//   - bit positions of the captured ALU flags inside rsp_flags
//   - width of the ALU operation select
// ----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int ALU_SEL_W  = 4;
    localparam int FLAG_W     = 3;

    // rsp_flags = {Overflow, Zero, Carry_Out}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at ptr+1 and wraps
// circularly, so the requester named by ptr (the last winner) has the lowest
// priority.
// Ports:
//   req         in   NUM_REQ  request vector
//   ptr         in   IDX_W    index of the previous winner
//   grant       out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx   out  IDX_W    binary index of the granted requester
//   grant_valid out  1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // One extra bit so ptr+k (at most 2*NUM_REQ-1) never overflows before
    // the modulo reduction.
    logic [IDX_W:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        // Walk from the farthest offset down to the nearest one so that the
        // closest requester after ptr overwrites any earlier hit.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                grant                   = '0;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
                grant_valid             = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational alu_32 between NUM_REQ requesters.
// A round-robin winner is accepted in IDLE, its operands are registered onto
// the ALU inputs, the ALU settles for one cycle (EXEC), and result/flags are
// captured and offered to the winner until it accepts them (RESP).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake
//   req_a/req_b/req_sel        packed operands/select, requester i at slice i
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_result/rsp_flags       captured ALU_Out and {Overflow, Zero, Carry}
//   alu_a/alu_b/alu_sel        registered drive to alu_32
//   alu_out/alu_carry/alu_zero/alu_overflow   alu_32 outputs
//   busy                       high outside IDLE
//   ops_done                   completed responses, wraps silently
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]      req_a,
    input  logic [NUM_REQ*DATA_W-1:0]      req_b,
    input  logic [NUM_REQ*ALU_SEL_W-1:0]   req_sel,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_W-1:0]              rsp_result,
    output logic [FLAG_W-1:0]              rsp_flags,
    output logic [DATA_W-1:0]              alu_a,
    output logic [DATA_W-1:0]              alu_b,
    output logic [ALU_SEL_W-1:0]           alu_sel,
    input  logic [DATA_W-1:0]              alu_out,
    input  logic                           alu_carry,
    input  logic                           alu_zero,
    input  logic                           alu_overflow,
    output logic                           busy,
    output logic [CNT_W-1:0]               ops_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [DATA_W-1:0]      alu_a_q, alu_a_d;
    logic [DATA_W-1:0]      alu_b_q, alu_b_d;
    logic [ALU_SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]      rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]      rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0]       ops_done_q, ops_done_d;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    // Unpacked views of the packed request buses.
    logic [DATA_W-1:0]      a_arr   [NUM_REQ];
    logic [DATA_W-1:0]      b_arr   [NUM_REQ];
    logic [ALU_SEL_W-1:0]   sel_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
            assign sel_arr[gi] = req_sel[gi*ALU_SEL_W +: ALU_SEL_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                // The arbiter only grants a valid requester, so a grant is
                // already a completed handshake.
                if (arb_valid) begin
                    alu_a_d   = a_arr[arb_idx];
                    alu_b_d   = b_arr[arb_idx];
                    alu_sel_d = sel_arr[arb_idx];
                    grant_d   = arb_idx;
                    ptr_d     = arb_idx;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d             = alu_out;
                rsp_flags_d[FLAG_OVF]    = alu_overflow;
                rsp_flags_d[FLAG_ZERO]   = alu_zero;
                rsp_flags_d[FLAG_CARRY]  = alu_carry;
                state_d                  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[grant_q]) begin
                    ops_done_d = ops_done_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IDX_W'(NUM_REQ-1);
            grant_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // req_ready is combinational from req_valid; gating with rst_n keeps it
    // low while reset is held even if requesters are already asserting valid.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? arb_grant : '0;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
            assign rsp_valid[gi] = (state_q == ST_RESP) && (grant_q == IDX_W'(gi));
        end
    endgenerate

    assign busy       = (state_q != ST_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign ops_done   = ops_done_q;

endmodule : alu_arbiter

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational alu_32 instance between NUM_REQ independent requesters.
- Each requester submits an operation with operands A, B and a 4-bit select over a valid/ready request channel.
- The block arbitrates round-robin, registers the winner's operands into the ALU, and captures result and flags.
- It returns them over a per-requester valid/ready response channel. Sits between client blocks and alu_32 at the datapath top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 32, operand/result width (must match alu_32)
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept
- req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand B
- req_sel  in  NUM_REQ*4  packed ALU select
- rsp_valid  out  NUM_REQ  per-requester response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_result  out  DATA_W  captured ALU_Out (shared, qualified by rsp_valid)
- rsp_flags  out  3  captured {Overflow, Zero, Carry_Out}
- alu_a  out  DATA_W  to alu_32 A_in
- alu_b  out  DATA_W  to alu_32 B_in
- alu_sel  out  4  to alu_32 ALU_Sel
- alu_out  in  DATA_W  from alu_32 ALU_Out
- alu_carry, alu_zero, alu_overflow  in  1 each  from alu_32 flags
- busy  out  1  high in any state other than IDLE
- ops_done  out  CNT_W  completed responses, wraps at 2^CNT_W

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_a/alu_b=0, alu_sel=0, busy=0, ops_done=0; rr pointer=NUM_REQ-1 so requester 0 has first priority.
- Reset mid-operation drops the in-flight op silently; requesters must reissue.
- States:
  - IDLE: winner = first i with req_valid[i], searching from pointer+1 circularly. req_ready[winner]=1 combinationally, all other bits 0; none valid -> all 0.
  - IDLE -> EXEC on handshake: register the winner's a/b/sel into alu_a/b/sel, store grant index, pointer := winner.
  - EXEC (1 cycle): ALU settles. At the clock edge, capture alu_out into rsp_result and {alu_overflow, alu_zero, alu_carry} into rsp_flags. -> RESP.
  - RESP: rsp_valid[grant]=1, others 0. result/flags held stable until rsp_ready[grant]=1. On that handshake: ops_done+1, -> IDLE.
- rsp_ready on non-granted bits is ignored.
- No request accepted in EXEC/RESP (req_ready=0). Minimum 3 cycles per op. Request-to-response latency is 2 cycles after acceptance.
- alu_a/b/sel hold their last value after the op (no toggling while idle).
- Requesters must hold req_* stable while valid and not ready. The block does not check this.
- All ALU_Sel codes pass through unmodified; illegal codes yield whatever alu_32 produces.
- Simultaneous valid from all requesters: strict rotation; each requester is served once per NUM_REQ ops.
- A requester whose valid drops before its grant is skipped, no penalty.
- ops_done wraps 0xFFFF -> 0x0000 without flag.

Decomposition:
- Shared header alu_arb_defs.vh: state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), flag bit positions (CARRY=0, ZERO=1, OVF=2), ALU_SEL_W=4.
- One sub-module rr_arbiter: inputs req vector and pointer, output one-hot grant plus index. Purely combinational, parameterised by NUM_REQ.
- alu_32 is instantiated beside this block at top level, not inside it.

Test Plan:
- Single op: req0 a=0x086a0c31 b=0xd785f148 sel=4'b0000 (add) -> req_ready[0] same cycle; rsp_valid[0] 2 cycles later; rsp_result=0xDFEFFD79, flags=3'b000; ops_done=1.
- Contention: req0 and req1 held valid continuously for 4 ops -> grant order 0,1,0,1; next op never accepted before prior rsp handshake; ops_done=4.
- Response backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and result stable all 5 cycles; req0 valid meanwhile gets req_ready[0]=0 until handshake, then accepted in next IDLE cycle.
- Reset mid-op: assert rst_n=0 during EXEC -> all outputs zero immediately (asynchronously); after release req0 has priority and no stale rsp_valid appears.
- Wrap: preload by running until ops_done=0xFFFF (or force), one more op -> ops_done=0x0000.
- Carry/zero flags: a=0xFFFFFFFF b=0x00000001 sel=4'b0000 -> result=0x00000000, flags Zero=1 Carry=1 Overflow=0 (3'b011).
